// File: rtl/uarch_pkg.sv
// uarch_pkg: shared micro-architecture definitions for the out-of-order core.
//
// Contents used by the retire-side performance monitor:
//   perf_state_t        - monitor phase (IDLE=0, RUN=1, SETTLE=2, HALT=3)
//   COMMIT_WIDTH_DEFAULT - retire lanes per cycle
//   PERF_CNT_W          - width of every performance counter
//   DONE_REG_DEFAULT    - architectural rd carrying the completion marker
//   DONE_VALUE_DEFAULT  - completion marker value
package uarch_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE   = 2'd0,
    PERF_RUN    = 2'd1,
    PERF_SETTLE = 2'd2,
    PERF_HALT   = 2'd3
  } perf_state_t;

  localparam int          COMMIT_WIDTH_DEFAULT = 2;
  localparam int          PERF_CNT_W           = 32;
  localparam int          DONE_REG_DEFAULT     = 31;
  localparam logic [31:0] DONE_VALUE_DEFAULT   = 32'h0000_00FF;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a multi-bit increment.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset (count -> 0)
//   clr      - synchronous clear, wins over enable
//   en       - add inc this cycle
//   inc      - increment amount, INC_W bits wide
//   count    - current value, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  // One guard bit above the wider operand so the overflow is visible.
  localparam int SW = ((W > INC_W) ? W : INC_W) + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] max_val;

  always_comb begin
    sum     = SW'(count) + SW'(inc);
    max_val = SW'({W{1'b1}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (sum > max_val) ? {W{1'b1}} : sum[W-1:0];
    end
  end

endmodule

// File: rtl/commit_perf_monitor.sv
// commit_perf_monitor: retire-side cycle / instruction / event monitor.
//
// Taps the commit stage's per-lane retire bus, counts cycles, retired
// instructions and generic events while a program runs, detects completion
// from an architectural write of DONE_VALUE to DONE_REG, holds a settle
// window, and flags a watchdog timeout.
//
// Ports:
//   clk, rst      - core clock, asynchronous active-high reset
//   start         - pulse: (re)start into RUN, clears counters and flags
//   commit_valid  - per-lane retire strobe
//   commit_we     - per-lane rd write enable
//   commit_rd     - per-lane architectural destination
//   commit_data   - per-lane writeback value
//   event_in      - per-cycle event strobes
//   cycle_cnt     - cycles spent in RUN and SETTLE
//   instr_cnt     - retired instructions
//   event_cnt     - per-event counts
//   state         - monitor phase (IDLE=0, RUN=1, SETTLE=2, HALT=3)
//   done          - completed normally (sticky)
//   timeout       - watchdog expired (sticky)
//   commit_hist   - (PERF_HIST_EN only) bin k counts cycles with k retirements
//
// Build option: define PERF_HIST_EN to add the retirement histogram.
// All counters saturate; every output is a register.
module commit_perf_monitor
  import uarch_pkg::*;
#(
  parameter int          COMMIT_WIDTH  = COMMIT_WIDTH_DEFAULT,
  parameter int          CNT_W         = PERF_CNT_W,
  parameter int          NUM_EVENTS    = 4,
  parameter int          MAX_CYCLES    = 10000,
  parameter int          SETTLE_CYCLES = 10,
  parameter int          DONE_REG      = DONE_REG_DEFAULT,
  parameter logic [31:0] DONE_VALUE    = DONE_VALUE_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [COMMIT_WIDTH-1:0]              commit_valid,
  input  logic [COMMIT_WIDTH-1:0]              commit_we,
  input  logic [COMMIT_WIDTH-1:0][4:0]         commit_rd,
  input  logic [COMMIT_WIDTH-1:0][31:0]        commit_data,
  input  logic [NUM_EVENTS-1:0]                event_in,
  output logic [CNT_W-1:0]                     cycle_cnt,
  output logic [CNT_W-1:0]                     instr_cnt,
  output logic [NUM_EVENTS-1:0][CNT_W-1:0]     event_cnt,
  output logic [1:0]                           state,
`ifdef PERF_HIST_EN
  output logic [COMMIT_WIDTH:0][CNT_W-1:0]     commit_hist,
`endif
  output logic                                 done,
  output logic                                 timeout
);

  localparam int RET_W = $clog2(COMMIT_WIDTH + 1);
  localparam int STL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Watchdog compare is done at least 32 bits wide so a narrow counter is
  // never compared against a truncated limit.
  localparam int WD_W  = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [STL_W-1:0] SETTLE_LOAD = STL_W'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(MAX_CYCLES - 1);

  perf_state_t      state_q, state_d;
  logic [STL_W-1:0] settle_q, settle_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic [RET_W-1:0] n_retire;
  logic             marker_hit;
  logic             wd_hit;
  logic             counting;
  logic             count_clr;

  // Retire popcount and completion-marker detection across all lanes.
  // rd==0 can never carry the marker since x0 is hardwired to zero.
  always_comb begin
    n_retire   = '0;
    marker_hit = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      n_retire = n_retire + RET_W'(commit_valid[i]);
      if (commit_valid[i] && commit_we[i] &&
          (commit_rd[i] == 5'(DONE_REG)) && (commit_rd[i] != 5'd0) &&
          (commit_data[i] == DONE_VALUE)) begin
        marker_hit = 1'b1;
      end
    end
  end

  assign wd_hit = (WD_W'(cycle_cnt) >= WD_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PERF_IDLE;
      settle_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. start overrides everything; completion beats the
  // watchdog when both happen in the same RUN cycle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = PERF_RUN;
    end else begin
      case (state_q)
        PERF_RUN: begin
          if (marker_hit)  state_d = PERF_SETTLE;
          else if (wd_hit) state_d = PERF_HALT;
        end
        PERF_SETTLE: begin
          if (settle_q == '0) state_d = PERF_HALT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output / datapath control.
  always_comb begin
    counting  = (state_q == PERF_RUN) || (state_q == PERF_SETTLE);
    count_clr = start;
    settle_d  = settle_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    if (start) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        PERF_RUN: begin
          if (marker_hit)  settle_d  = SETTLE_LOAD;
          else if (wd_hit) timeout_d = 1'b1;
        end
        PERF_SETTLE: begin
          if (settle_q == '0) done_d   = 1'b1;
          else                settle_d = settle_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign done    = done_q;
  assign timeout = timeout_q;

  sat_counter #(.W(CNT_W), .INC_W(1)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clr),
    .en    (counting),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W), .INC_W(RET_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clr),
    .en    (counting),
    .inc   (n_retire),
    .count (instr_cnt)
  );

  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_event
    sat_counter #(.W(CNT_W), .INC_W(1)) u_event_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (count_clr),
      .en    (counting),
      .inc   (event_in[e]),
      .count (event_cnt[e])
    );
  end

`ifdef PERF_HIST_EN
  for (genvar k = 0; k <= COMMIT_WIDTH; k++) begin : g_hist
    logic bin_hit;
    assign bin_hit = (n_retire == RET_W'(k));
    sat_counter #(.W(CNT_W), .INC_W(1)) u_bin (
      .clk   (clk),
      .rst   (rst),
      .clr   (count_clr),
      .en    (counting),
      .inc   (bin_hit),
      .count (commit_hist[k])
    );
  end
`endif

endmodule

// File: tb/tb_commit_perf_monitor.sv
// Testbench for commit_perf_monitor. Three instances share the retire bus:
// default build (sel 0), MAX_CYCLES=50 (sel 1) and CNT_W=4 (sel 2); only the
// selected instance is compared against the reference model each cycle.
module tb_commit_perf_monitor;

  localparam int CW = 2;
  localparam int NE = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_SETTLE = 2, P_HALT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_m, start_w, start_s;
  logic [CW-1:0]       valid, we;
  logic [CW-1:0][4:0]  rd;
  logic [CW-1:0][31:0] data;
  logic [NE-1:0]       ev;

  logic [31:0] cyc_m, ins_m, cyc_w, ins_w;
  logic [3:0]  cyc_s, ins_s;
  logic [NE-1:0][31:0] ev_m, ev_w;
  logic [NE-1:0][3:0]  ev_s;
  logic [1:0] st_m, st_w, st_s;
  logic dn_m, dn_w, dn_s, to_m, to_w, to_s;
`ifdef PERF_HIST_EN
  logic [CW:0][31:0] h_m, h_w;
  logic [CW:0][3:0]  h_s;
`endif

  commit_perf_monitor dut_main (
    .clk(clk), .rst(rst), .start(start_m), .commit_valid(valid), .commit_we(we),
    .commit_rd(rd), .commit_data(data), .event_in(ev), .cycle_cnt(cyc_m),
    .instr_cnt(ins_m), .event_cnt(ev_m), .state(st_m),
`ifdef PERF_HIST_EN
    .commit_hist(h_m),
`endif
    .done(dn_m), .timeout(to_m));

  commit_perf_monitor #(.MAX_CYCLES(50)) dut_wd (
    .clk(clk), .rst(rst), .start(start_w), .commit_valid(valid), .commit_we(we),
    .commit_rd(rd), .commit_data(data), .event_in(ev), .cycle_cnt(cyc_w),
    .instr_cnt(ins_w), .event_cnt(ev_w), .state(st_w),
`ifdef PERF_HIST_EN
    .commit_hist(h_w),
`endif
    .done(dn_w), .timeout(to_w));

  commit_perf_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .commit_valid(valid), .commit_we(we),
    .commit_rd(rd), .commit_data(data), .event_in(ev), .cycle_cnt(cyc_s),
    .instr_cnt(ins_s), .event_cnt(ev_s), .state(st_s),
`ifdef PERF_HIST_EN
    .commit_hist(h_s),
`endif
    .done(dn_s), .timeout(to_s));

  // Observed outputs of the selected instance, widened to 32 bits.
  int sel;
  logic [1:0]  o_state;
  logic [31:0] o_cycle, o_instr;
  logic [31:0] o_ev [NE];
  logic        o_done, o_to;
`ifdef PERF_HIST_EN
  logic [31:0] o_hist [CW+1];
`endif

  always_comb begin
    case (sel)
      1: begin
        o_state = st_w; o_cycle = cyc_w; o_instr = ins_w; o_done = dn_w; o_to = to_w;
        for (int i = 0; i < NE; i++) o_ev[i] = ev_w[i];
`ifdef PERF_HIST_EN
        for (int k = 0; k <= CW; k++) o_hist[k] = h_w[k];
`endif
      end
      2: begin
        o_state = st_s; o_cycle = {28'd0, cyc_s}; o_instr = {28'd0, ins_s};
        o_done = dn_s; o_to = to_s;
        for (int i = 0; i < NE; i++) o_ev[i] = {28'd0, ev_s[i]};
`ifdef PERF_HIST_EN
        for (int k = 0; k <= CW; k++) o_hist[k] = {28'd0, h_s[k]};
`endif
      end
      default: begin
        o_state = st_m; o_cycle = cyc_m; o_instr = ins_m; o_done = dn_m; o_to = to_m;
        for (int i = 0; i < NE; i++) o_ev[i] = ev_m[i];
`ifdef PERF_HIST_EN
        for (int k = 0; k <= CW; k++) o_hist[k] = h_m[k];
`endif
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (sel %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Unsaturated running totals; saturation applied only when comparing.
  int              m_phase;
  longint unsigned m_cyc, m_instr;
  longint unsigned m_ev [NE];
  longint unsigned m_hist [CW+1];
  bit              m_done, m_to;
  int              m_settle_left;
  longint unsigned m_cnt_max, m_max_cycles;

  function automatic longint unsigned satv(input longint unsigned v);
    return (v > m_cnt_max) ? m_cnt_max : v;
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_instr = 0; m_done = 0; m_to = 0; m_settle_left = 0;
    for (int i = 0; i < NE; i++) m_ev[i] = 0;
    for (int k = 0; k <= CW; k++) m_hist[k] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_phase = P_IDLE;
  endtask

  task automatic select_dut(input int s);
    sel          = s;
    m_cnt_max    = (s == 2) ? 64'd15 : 64'hFFFF_FFFF;
    m_max_cycles = (s == 1) ? 64'd50 : 64'd10000;
  endtask

  // One clock edge of the monitor as seen from the retire bus.
  task automatic model_step(input logic st);
    int n;
    bit hit;
    n = 0; hit = 0;
    for (int l = 0; l < CW; l++) begin
      if (valid[l]) n++;
      if (valid[l] && we[l] && rd[l] == 5'd31 && data[l] == 32'hFF) hit = 1;
    end
    if (st) begin
      model_clear();
      m_phase = P_RUN;
    end else if (m_phase == P_RUN || m_phase == P_SETTLE) begin
      m_cyc++;
      m_instr += n;
      for (int i = 0; i < NE; i++) m_ev[i] += ev[i];
      m_hist[n]++;
      if (m_phase == P_RUN) begin
        if (hit) begin
          m_phase = P_SETTLE;
          m_settle_left = 10;
        end else if (m_cyc >= m_max_cycles) begin
          m_phase = P_HALT;
          m_to = 1;
        end
      end else begin
        m_settle_left--;
        if (m_settle_left == 0) begin
          m_phase = P_HALT;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("state", o_state, m_phase);
    check("cycle_cnt", o_cycle, satv(m_cyc));
    check("instr_cnt", o_instr, satv(m_instr));
    check("done", o_done, m_done);
    check("timeout", o_to, m_to);
    for (int i = 0; i < NE; i++) check($sformatf("event_cnt%0d", i), o_ev[i], satv(m_ev[i]));
`ifdef PERF_HIST_EN
    for (int k = 0; k <= CW; k++) check($sformatf("hist%0d", k), o_hist[k], satv(m_hist[k]));
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    valid = '0; we = '0; rd = '0; data = '0; ev = '0;
  endtask

  task automatic drive_lane(input int l, input logic v, input logic w,
                            input logic [4:0] r, input logic [31:0] d);
    valid[l] = v; we[l] = w; rd[l] = r; data[l] = d;
  endtask

  task automatic drive_random(input bit allow_marker);
    for (int l = 0; l < CW; l++) begin
      valid[l] = 1'($urandom_range(0, 1));
      we[l]    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rd[l] = 5'd31;
        1:       rd[l] = 5'd30;
        2:       rd[l] = 5'd0;
        default: rd[l] = 5'($urandom_range(1, 31));
      endcase
      case ($urandom_range(0, 2))
        0:       data[l] = 32'hFF;
        1:       data[l] = 32'hFE;
        default: data[l] = $urandom;
      endcase
      if (!allow_marker && data[l] == 32'hFF) data[l] = 32'hFE;
    end
    ev = 4'($urandom_range(0, 15));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick(input logic st);
    start_m = (sel == 0) ? st : 1'b0;
    start_w = (sel == 1) ? st : 1'b0;
    start_s = (sel == 2) ? st : 1'b0;
    @(posedge clk);
    model_step(st);
    #1;
    compare_all();
    @(negedge clk);
    start_m = 1'b0; start_w = 1'b0; start_s = 1'b0;
  endtask

  // Random program: quiet prefix, then markers allowed, then a forced marker,
  // then enough cycles to settle and sit in HALT.
  task automatic run_program(input int pre_len, input int restart_at);
    drive_random(0);
    tick(1'b1);
    for (int c = 0; c < pre_len; c++) begin
      drive_random(0);
      tick(c == restart_at);
    end
    for (int c = 0; c < 40 && m_phase == P_RUN; c++) begin
      drive_random(1);
      tick(1'b0);
    end
    if (m_phase == P_RUN) begin
      int l;
      drive_random(0);
      l = $urandom_range(0, 1);
      drive_lane(l, 1'b1, 1'b1, 5'd31, 32'hFF);
      tick(1'b0);
    end
    for (int c = 0; c < 15; c++) begin
      drive_random(1);
      tick(1'b0);
    end
    check("prog_state_halt", o_state, P_HALT);
    check("prog_done", o_done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start_m = 1'b0; start_w = 1'b0; start_s = 1'b0;
    drive_idle();
    select_dut(0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    drive_random(0);
    tick(1'b0);  // IDLE holds without start

    // Throughput scenario.
    drive_idle();
    tick(1'b1);
    for (int c = 0; c < 200; c++) begin
      drive_idle();
      ev = 4'($urandom_range(0, 15));
      for (int l = 0; l < CW; l++) begin
        if ((c < 100) || (c < 150 && l == 0))
          drive_lane(l, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), $urandom);
      end
      tick(1'b0);
    end
    drive_idle();
    drive_lane(0, 1'b1, 1'b1, 5'd31, 32'hFF);
    tick(1'b0);
    check("thru_marker_state", o_state, P_SETTLE);
    check("thru_instr", o_instr, 251);
    drive_idle();
    repeat (10) tick(1'b0);
    check("thru_state", o_state, P_HALT);
    check("thru_cycle", o_cycle, 211);
    check("thru_done", o_done, 1);
`ifdef PERF_HIST_EN
    begin
      longint unsigned s0, s1;
      s0 = 0; s1 = 0;
      for (int k = 0; k <= CW; k++) begin
        s0 += o_hist[k];
        s1 += k * o_hist[k];
      end
      check("hist_sum_cycles", s0, m_cyc);
      check("hist_sum_instr", s1, m_instr);
    end
`endif

    // Marker filtering.
    drive_idle();
    tick(1'b1);
    drive_idle(); drive_lane(0, 1'b1, 1'b1, 5'd31, 32'hFE); tick(1'b0);
    check("filt_data_fe", o_state, P_RUN);
    drive_idle(); drive_lane(0, 1'b1, 1'b1, 5'd30, 32'hFF); tick(1'b0);
    check("filt_rd_30", o_state, P_RUN);
    drive_idle(); drive_lane(0, 1'b1, 1'b0, 5'd31, 32'hFF); tick(1'b0);
    check("filt_we_0", o_state, P_RUN);
    drive_idle(); drive_lane(1, 1'b1, 1'b1, 5'd31, 32'hFF); tick(1'b0);
    check("filt_lane1", o_state, P_SETTLE);
    drive_idle();
    repeat (12) tick(1'b0);

    // Randomized programs, some restarted mid-run.
    for (int it = 0; it < 8; it++) begin
      int len;
      len = $urandom_range(5, 60);
      run_program(len, (it % 3 == 1) ? len / 2 : -1);
    end

    // Watchdog.
    select_dut(1);
    model_reset();
    m_phase = st_w;  // the instance may have been left anywhere; start clears it
    drive_idle();
    tick(1'b1);
    for (int c = 0; c < 60; c++) begin
      drive_random(0);
      tick(1'b0);
    end
    check("wd_cycle", o_cycle, 50);
    check("wd_timeout", o_to, 1);
    check("wd_done", o_done, 0);
    check("wd_state", o_state, P_HALT);

    // Saturation with 4-bit counters.
    select_dut(2);
    drive_idle();
    tick(1'b1);
    for (int c = 0; c < 10; c++) begin
      drive_idle();
      drive_lane(0, 1'b1, 1'b0, 5'd1, 32'h0);
      drive_lane(1, 1'b1, 1'b0, 5'd2, 32'h0);
      tick(1'b0);
    end
    check("sat_instr", o_instr, 15);
    check("sat_cycle", o_cycle, 10);
    for (int c = 0; c < 10; c++) begin
      drive_random(0);
      tick(1'b0);
    end
    check("sat_cycle_hold", o_cycle, 15);

    // Async reset while in SETTLE.
    select_dut(0);
    drive_idle();
    tick(1'b1);
    for (int c = 0; c < 15; c++) begin
      drive_random(0);
      tick(1'b0);
    end
    drive_idle(); drive_lane(0, 1'b1, 1'b1, 5'd31, 32'hFF); tick(1'b0);
    drive_idle();
    repeat (3) tick(1'b0);
    check("ar_pre_state", o_state, P_SETTLE);
    #2 rst = 1'b1;
    #1;
    check("ar_state", o_state, P_IDLE);
    check("ar_cycle", o_cycle, 0);
    check("ar_instr", o_instr, 0);
    check("ar_event0", o_ev[0], 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    run_program(20, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
